// File: rtl/ysyx_25040111_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready issue and result handshakes.
// Define YSYX_25040111_MDU_RADIX4_EN to retire two multiplier bits per cycle.
module ysyx_25040111_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_res,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef YSYX_25040111_MDU_RADIX4_EN
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / 2);
`else
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN);
`endif
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
`ifdef YSYX_25040111_MDU_RADIX4_EN
  logic [XLEN+1:0]   m3_q, m3_d;
`endif

  logic            accept, in_div, s1, s2, special;
  logic [XLEN-1:0] abs1, abs2, special_res, fix_res;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN:0]   shl, diff;

  assign in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Operand preparation: magnitudes and result sign for the signed variants
  assign in_div = funct3[2];
  assign s1 = rs1[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_MULHSU) |
                             (funct3 == F_DIV)  | (funct3 == F_REM));
  assign s2 = rs2[XLEN-1] & ((funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM));
  assign abs1 = neg_x(rs1, s1);
  assign abs2 = neg_x(rs2, s2);

  assign special = in_div & ((rs2 == '0) |
                   ((~funct3[0]) & (rs1 == XMIN) & (rs2 == '1)));
  assign special_res = (rs2 == '0) ? (funct3[1] ? rs1 : '1)
                                   : (funct3[1] ? '0  : rs1);

  // One multiply step: conditionally add multiplicand to the high half, shift right
`ifdef YSYX_25040111_MDU_RADIX4_EN
  logic [XLEN+1:0] pp4, sum4;
  always_comb begin
    case (acc_q[1:0])
      2'd0:    pp4 = '0;
      2'd1:    pp4 = {2'b00, m_q};
      2'd2:    pp4 = {1'b0, m_q, 1'b0};
      default: pp4 = m3_q;
    endcase
  end
  assign sum4     = {2'b00, acc_q[2*XLEN-1:XLEN]} + pp4;
  assign mul_next = {sum4, acc_q[XLEN-1:2]};
`else
  logic [XLEN:0] sum2;
  assign sum2     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {sum2, acc_q[XLEN-1:1]};
`endif

  // One restoring-divide step: remainder in the high half, quotient shifts into the low half
  assign shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff = shl - {1'b0, m_q};
  assign div_next = diff[XLEN] ? {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = neg_2x(acc_q, neg_q);
  always_comb begin
    case (op_q)
      F_MUL:                   fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011:  fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:          fix_res = neg_x(acc_q[XLEN-1:0], neg_q);
      default:                 fix_res = neg_x(acc_q[2*XLEN-1:XLEN], neg_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    m_d     = m_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifdef YSYX_25040111_MDU_RADIX4_EN
    m3_d    = m3_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          res_d   = fix_res;
          state_d = S_DONE;
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
      if (accept) begin
        op_d  = funct3;
        rd_d  = rd_in;
        neg_d = (funct3 == F_REM) ? s1 : (s1 ^ s2);
        m_d   = in_div ? abs2 : abs1;
        acc_d = {{XLEN{1'b0}}, (in_div ? abs1 : abs2)};
        cnt_d = in_div ? DIV_ITERS : MUL_ITERS;
`ifdef YSYX_25040111_MDU_RADIX4_EN
        m3_d  = {2'b00, abs1} + {1'b0, abs1, 1'b0};
`endif
        if (special) begin
          res_d   = special_res;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
`ifdef YSYX_25040111_MDU_RADIX4_EN
      m3_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
`ifdef YSYX_25040111_MDU_RADIX4_EN
      m3_q    <= m3_d;
`endif
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_rd    = rd_q;
  assign out_res   = res_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/ysyx_25040111_mdu.md
Name: ysyx_25040111_mdu

Overview:
Parametrised iterative multiply/divide execution unit implementing the RV32M (XLEN-generic) M-extension operations. Sits beside the main EXU ALU: the EXU issues M-type ops through a valid/ready handshake. Results return through a second valid/ready handshake to the write-back arbiter, tagged with the destination register. Supports a pipeline flush and is the first multi-cycle, variable-latency execute path in the core.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  EXU issues an M op
in_ready  output  1  MDU can accept an op this cycle
funct3  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  operand 1 (multiplicand / dividend)
rs2  input  XLEN  operand 2 (multiplier / divisor)
rd_in  input  5  destination register address
flush  input  1  abort any in-flight op
out_valid  output  1  result available
out_ready  input  1  write-back accepts result
out_rd  output  5  latched destination register
out_res  output  XLEN  result
busy  output  1  op in flight (state != IDLE)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_res=0, out_rd=0, busy=0, counter=0.
- in_ready = ~flush & (IDLE | (DONE & out_ready)). Accept on in_valid & in_ready; funct3, rd_in and operands are latched on that edge.
- States and transitions:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept of a special case.
  - CALC -> FIX after the last iteration.
  - FIX -> DONE.
  - DONE -> IDLE on out_ready.
  - DONE -> CALC/DONE when a new op is accepted in the same cycle as out_ready (back-to-back).
- Operand prep at accept:
  - Signed ops (MULH rs1,rs2; MULHSU rs1 only; DIV/REM both) take absolute values.
  - Record the result sign: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
- Multiply: shift-add, 1 multiplier bit per cycle, XLEN iterations into a 2*XLEN accumulator.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits after sign correction.
- Divide: restoring, 1 quotient bit per cycle, XLEN iterations, producing quotient and remainder.
- FIX: one cycle; two's-complement negation of the full 2*XLEN product, or of quotient/remainder, per recorded sign; then selects the result.
- Latency: out_valid rises XLEN+2 cycles after the accept edge (32-bit: 34).
- Special cases (no CALC, out_valid one cycle after accept):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow, rs1 = 1<<(XLEN-1) with rs2 = all ones: DIV -> rs1; REM -> 0.
- Backpressure: while out_valid & ~out_ready, out_res and out_rd stay stable and no state advances.
- flush: takes priority over everything except reset. Next state = IDLE with out_valid=0, including in DONE; an accepted result in DONE is discarded. in_ready is 0 during the flush cycle.
- Reset mid-operation: same effect as flush, plus all registers are cleared.

Optional Feature:
YSYX_25040111_MDU_RADIX4_EN
- Defined: multiply uses radix-4 (2 multiplier bits/cycle, partial products 0/1x/2x/3x, with 3x precomputed at accept). Multiply takes XLEN/2 iterations, so latency is XLEN/2+2 (32-bit: 18). Divide is unchanged.
- Undefined: radix-2 multiply as above. Results are bit-identical in both builds.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> out_res=0xFFFFFFEB, out_valid 34 cycles after accept (18 with RADIX4_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2; rd_in=5 returned on out_rd.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 % 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; each with out_valid exactly 1 cycle after accept.
- DIV started, flush asserted 10 cycles after accept -> out_valid never rises, in_ready=1 next cycle, and a following MUL 3x4 returns 12.
- Backpressure: result ready but out_ready=0 for 5 cycles -> out_res/out_rd stable, in_ready=0. Then out_ready=1 with in_valid=1 (MUL 2x3) -> handshake and accept in the same cycle, next result 6.
